// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-select adder among requesters.
// Optional signed-overflow output: define ADDER_SHARE_OVF_EN to add rsp_ovf.

module carry_select_adder (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  localparam int NB = 8;

  logic [NB:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [3:0] w_s0;
    logic [3:0] w_s1;
    logic       w_c0;
    logic       w_c1;

    assign {w_c0, w_s0} = {1'b0, i_a[g*4 +: 4]}
                        + {1'b0, i_b[g*4 +: 4]};
    assign {w_c1, w_s1} = {1'b0, i_a[g*4 +: 4]}
                        + {1'b0, i_b[g*4 +: 4]}
                        + 5'd1;

    assign o_sum[g*4 +: 4] = w_c[g] ? w_s1 : w_s0;
    assign w_c[g+1]        = w_c[g] ? w_c1 : w_c0;
  end

  assign o_cout = w_c[NB];

endmodule

module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_sum,
  output logic                  rsp_cout
`ifdef ADDER_SHARE_OVF_EN
  ,
  output logic                  rsp_ovf
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      (2**ID_W) < NUM_REQ) begin : g_bad_cfg
    $error("adder_share_arbiter: bad NUM_REQ/ID_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ID_W-1:0] r_rr_ptr;
  logic [31:0]     r_op_a;
  logic [31:0]     r_op_b;
  logic            r_op_cin;
  logic [ID_W-1:0] r_op_id;

  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic [31:0]     r_rsp_sum;
  logic            r_rsp_cout;

  logic [31:0]     w_a [NUM_REQ];
  logic [31:0]     w_b [NUM_REQ];
  logic [ID_W:0]   w_pick;
  logic            w_any;
  logic [ID_W-1:0] w_grant;
  logic            w_accept;
  logic            w_done;
  logic [ID_W-1:0] w_next_ptr;
  logic [NUM_REQ-1:0] w_ready;
  logic [31:0]     w_sum;
  logic            w_cout;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_a[i] = req_a[32*i +: 32];
    assign w_b[i] = req_b[32*i +: 32];
  end

  // First valid index at or above p, wrapping; MSB flags a hit.
  function automatic logic [ID_W:0] f_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [ID_W-1:0]    p
  );
    logic [ID_W:0] r;
    int            j;
    r = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (v[j]) r = {1'b1, ID_W'(j)};
    end
    return r;
  endfunction

  assign w_pick  = f_pick(req_valid, r_rr_ptr);
  assign w_any   = w_pick[ID_W];
  assign w_grant = w_pick[ID_W-1:0];

  assign w_next_ptr =
    (r_op_id == ID_W'(NUM_REQ-1)) ? '0
                                  : r_op_id + 1'b1;

  carry_select_adder u_add (
    .i_a    (r_op_a),
    .i_b    (r_op_b),
    .i_cin  (r_op_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Next-state, grant strobe and handshake events.
  always_comb begin
    w_next   = r_state;
    w_ready  = '0;
    w_accept = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any && !rst) begin
          w_ready[w_grant] = 1'b1;
          w_accept         = 1'b1;
          w_next           = EXEC;
        end
      end
      EXEC: begin
        w_next = RESP;
      end
      RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Operand capture on grant; pointer moves only when a response retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_cin <= 1'b0;
      r_op_id  <= '0;
    end else begin
      if (w_accept) begin
        r_op_a   <= w_a[w_grant];
        r_op_b   <= w_b[w_grant] ^ {32{req_sub[w_grant]}};
        r_op_cin <= req_sub[w_grant];
        r_op_id  <= w_grant;
      end
      if (w_done) r_rr_ptr <= w_next_ptr;
    end
  end

  // Response registers: loaded in EXEC, held through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
    end else if (r_state == EXEC) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_op_id;
      r_rsp_sum   <= w_sum;
      r_rsp_cout  <= w_cout;
    end else if (w_done) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef ADDER_SHARE_OVF_EN
  logic r_rsp_ovf;
  logic w_ovf;

  assign w_ovf = (r_op_a[31] == r_op_b[31]) &
                 (w_sum[31] != r_op_a[31]);

  // Signed overflow captured with the sum.
  always_ff @(posedge clk) begin
    if (rst)                   r_rsp_ovf <= 1'b0;
    else if (r_state == EXEC)  r_rsp_ovf <= w_ovf;
  end

  assign rsp_ovf = r_rsp_ovf;
`endif

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter.
// Define ADDER_SHARE_OVF_EN to also exercise rsp_ovf.

module tb_adder_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_sub;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_sum;
  logic                  rsp_cout;
`ifdef ADDER_SHARE_OVF_EN
  logic                  rsp_ovf;
`endif

  int n_chk;
  int n_err;

  adder_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef ADDER_SHARE_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (req_ready == '0 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 10) begin
      step();
      n++;
    end
  endtask

  task automatic do_op(input int          idx,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic        sub,
                       input logic [31:0] es,
                       input logic        ec,
                       input logic        eo);
    int n;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_sub[idx]        = sub;
    req_valid[idx]      = 1'b1;
    rsp_ready           = 1'b1;
    #1;
    wait_ready(10);
    chk("grant", 32'(req_ready), 32'(1 << idx));
    step();
    req_valid[idx] = 1'b0;
    chk("exec_valid", 32'(rsp_valid), 0);
    chk("exec_ready", 32'(req_ready), 0);
    wait_rsp(n);
    chk("latency", n, 1);
    chk("rsp_id", 32'(rsp_id), idx);
    chk("rsp_sum", rsp_sum, es);
    chk("rsp_cout", 32'(rsp_cout), 32'(ec));
`ifdef ADDER_SHARE_OVF_EN
    chk("rsp_ovf", 32'(rsp_ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: ovf x");
`endif
    step();
    chk("rsp_done", 32'(rsp_valid), 0);
  endtask

  logic [31:0] t3_a [4];
  logic [31:0] t3_b [4];
  logic [31:0] t3_s [4];
  logic [31:0] h_sum;
  logic [ID_W-1:0] h_id;

  initial begin
    int n;
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;
    t3_a = '{32'h11, 32'h22, 32'h33, 32'h44};
    t3_b = '{32'h1, 32'h2, 32'h3, 32'h4};
    t3_s = '{32'h12, 32'h24, 32'h36, 32'h48};

    repeat (3) step();
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_cout", 32'(rsp_cout), 0);
    rst = 1'b0;
    step();

    // 1: simple add
    do_op(0, 32'h5, 32'h3, 1'b0, 32'h8, 1'b0, 1'b0);

    // 2: wrap add, then subtract with borrow
    do_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0,
          32'h0, 1'b1, 1'b0);
    do_op(1, 32'h3, 32'h5, 1'b1,
          32'hFFFF_FFFE, 1'b0, 1'b0);

    // 3: round robin with all valid
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = t3_a[i];
      req_b[i*32 +: 32] = t3_b[i];
    end
    req_sub   = '0;
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      wait_ready(10);
      chk("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
      chk("rr_onehot", 32'($onehot0(req_ready)), 1);
      step();
      chk("rr_exec_rdy", 32'(req_ready), 0);
      wait_rsp(n);
      chk("rr_resp_rdy", 32'(req_ready), 0);
      chk("rr_id", 32'(rsp_id), g % 4);
      chk("rr_sum", rsp_sum, t3_s[g % 4]);
      step();
    end
    req_valid = '0;

    // 4: backpressure
    req_a[2*32 +: 32] = 32'd100;
    req_b[2*32 +: 32] = 32'd23;
    req_sub[2]        = 1'b1;
    req_valid         = 4'b1100;
    rsp_ready         = 1'b0;
    #1;
    wait_ready(10);
    chk("bp_grant", 32'(req_ready), 32'h4);
    step();
    req_valid[2] = 1'b0;
    wait_rsp(n);
    h_sum = rsp_sum;
    h_id  = rsp_id;
    chk("bp_sum", h_sum, 32'd77);
    chk("bp_cout", 32'(rsp_cout), 1);
    chk("bp_id", 32'(h_id), 2);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_v", 32'(rsp_valid), 1);
      chk("bp_hold_s", rsp_sum, h_sum);
      chk("bp_hold_i", 32'(rsp_id), 32'(h_id));
      chk("bp_hold_r", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release", 32'(rsp_valid), 0);
    chk("bp_idle_rdy", 32'(req_ready), 32'h8);
    req_valid = '0;
    step();

    // 5: reset during EXEC
    req_valid = 4'b1010;
    #1;
    chk("rx_grant", 32'(req_ready), 32'h8);
    step();
    req_valid[3] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rx_valid", 32'(rsp_valid), 0);
    chk("rx_sum", rsp_sum, 0);
    chk("rx_id", 32'(rsp_id), 0);
    chk("rx_cout", 32'(rsp_cout), 0);
    chk("rx_ptr0", 32'(req_ready), 32'h2);
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rx_no_rsp", 32'(rsp_valid), 0);
    end

`ifdef ADDER_SHARE_OVF_EN
    // 6: signed overflow
    do_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0,
          32'h8000_0000, 1'b0, 1'b1);
    do_op(0, 32'h8000_0000, 32'h1, 1'b1,
          32'h7FFF_FFFF, 1'b1, 1'b1);
    do_op(0, 32'h5, 32'h3, 1'b0,
          32'h8, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
